instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Parametrised instruction fetch unit: owns the program counter, holds program memory, and delivers instructions with their PCs to the decode stage through a valid/ready handshake. A small prefetch queue decouples memory reads from decode stalls. Supports redirect (branch/jump) with queue flush, and a write port for loading program memory. It replaces the fixed 16-bit/1024-word instruction register with free-running PC in the processor front end.

## Interface
- DATA_W, 16, instruction width in bits
- ADDR_W, 10, PC/memory address width; memory depth = 2**ADDR_W words
- FIFO_DEPTH, 4, prefetch queue entries (>= 2)
- RESET_PC, 0, PC value loaded on reset

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- instr  out  DATA_W  instruction at queue head
- instr_pc  out  ADDR_W  address of instr
- instr_valid  out  1  queue head holds a valid instruction
- instr_ready  in  1  decode accepts head this cycle
- branch_en  in  1  redirect fetch this cycle
- branch_target  in  ADDR_W  new fetch address
- prog_we  in  1  program memory write enable
- prog_addr  in  ADDR_W  write address
- prog_wdata  in  DATA_W  write data
- fill_count  out  clog2(FIFO_DEPTH+1)  queued entries

## Operation
- State: fetch_pc (ADDR_W), rd_vld (1), rd_data/rd_pc (read stage register), queue of FIFO_DEPTH {data, pc} entries with head/tail pointers and count.
- Issue: in cycle N, if !reset, !branch_en and count + rd_vld < FIFO_DEPTH: rd_data <= mem[fetch_pc], rd_pc <= fetch_pc, rd_vld <= 1, fetch_pc <= fetch_pc + 1 modulo 2**ADDR_W (2**ADDR_W-1 wraps to 0). Else rd_vld <= 0, fetch_pc held.
- Push: when rd_vld is 1 at a cycle end, {rd_data, rd_pc} is written at tail. Issue condition guarantees space; a push into a full queue cannot occur.
- Pop: instr_valid & instr_ready at a cycle end removes head. Push and pop in the same cycle leave count unchanged.
- instr_valid = (count != 0); instr/instr_pc = head entry (combinational from queue storage); fill_count = count.
- Redirect: branch_en has priority over everything except reset. At the cycle end: queue emptied (count 0, pointers reset), rd_vld <= 0 (in-flight read discarded), fetch_pc <= branch_target. A handshake coinciding with branch_en is discarded; decode must treat it as not taken.
- Program write: prog_we writes mem[prog_addr] at cycle end, independent of fetch. Read and write to same address same cycle: read returns old data. Entries already in the queue or read stage are not updated; software redirects after self-modification.
- Memory is not cleared by reset.

## Timing
- Reset: fetch_pc = RESET_PC, rd_vld = 0, count = 0 → instr_valid = 0, fill_count = 0; instr/instr_pc don't-care while invalid. Reset mid-operation discards queued and in-flight instructions identically.
- Latency: first cycle with reset low = cycle 0 issues RESET_PC; instr_valid first high in cycle 2.
- Redirect latency: branch_en in cycle B → issue of branch_target in B+1 → instr_valid with instr_pc = branch_target in B+3.
- Throughput: with instr_ready held high, one instruction per cycle sustained.
- Backpressure: with instr_ready low, queue fills to exactly FIFO_DEPTH, fetch stops, fetch_pc = last queued pc + 1 (mod depth).

## Test plan
- Reset, mem[i] = i+100 for i<8, ready=1 → valid from cycle 2, instr 100,101,102… one per cycle, instr_pc 0,1,2….
- Hold ready=0 from cycle 0 → fill_count rises to 4 and stops; raise ready → 100..103 then 104.. with no gap or duplicate.
- branch_en, target 0x200, while queue holds 3 entries and ready=1 → queue flushed same edge, valid low B+1..B+2, instr_pc 0x200 at B+3, then 0x201.
- Branch to 0x3FE (ADDR_W=10) → instr_pc sequence 0x3FE, 0x3FF, 0x000, 0x001.
- prog_we writes addr 5 = 0xBEEF while fetch issues addr 5 same cycle → old value delivered; after branch to 5, 0xBEEF delivered.
- Assert reset for one cycle with full queue → next cycle instr_valid=0, fill_count=0; restart fetches from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode bus: instruction delivery, redirect and program-memory write port.
// Handshake: a head entry transfers on a rising edge where instr_valid & instr_ready are both high,
// unless branch_en is high that cycle; instr/instr_pc stay stable while instr_valid is high and unaccepted.
interface instr_fetch_unit_if #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_target;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_wdata;
  logic [CNT_W-1:0]  fill_count;

  modport master (
    output instr, instr_pc, instr_valid, fill_count,
    input  instr_ready, branch_en, branch_target, prog_we, prog_addr, prog_wdata
  );

  modport slave (
    input  instr, instr_pc, instr_valid, fill_count,
    output instr_ready, branch_en, branch_target, prog_we, prog_addr, prog_wdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, program memory, one-cycle read stage and a prefetch queue
// feeding decode; redirect flushes everything in flight.
module instr_fetch_unit #(
  parameter int                 DATA_W     = 16,
  parameter int                 ADDR_W     = 10,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
  input logic                  clk,
  input logic                  reset,
  instr_fetch_unit_if.master   bus
);
  localparam int               CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] rd_pc_q;

  logic [DATA_W-1:0] q_data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] q_pc_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              issue;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    occupancy;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // A read is only issued when its result is guaranteed a queue slot, so push never overflows.
  always_comb begin
    occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, rd_vld_q};
    issue      = !bus.branch_en && (occupancy < DEPTH_C);
    push       = rd_vld_q;
    pop        = (count_q != '0) && bus.instr_ready;
    fetch_pc_d = fetch_pc_q;
    rd_vld_d   = issue;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (bus.branch_en) begin
      fetch_pc_d = bus.branch_target;
      rd_vld_d   = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      if (push)  tail_d     = next_ptr(tail_q);
      if (pop)   head_d     = next_ptr(head_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rd_vld_q   <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_vld_q   <= rd_vld_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Read stage: a same-cycle program write is seen by the next read, not this one.
  always_ff @(posedge clk) begin
    if (!reset && issue) begin
      rd_data_q <= mem_q[fetch_pc_q];
      rd_pc_q   <= fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data_q[tail_q] <= rd_data_q;
      q_pc_q[tail_q]   <= rd_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.prog_we) mem_q[bus.prog_addr] <= bus.prog_wdata;
  end

  assign bus.instr       = q_data_q[head_q];
  assign bus.instr_pc    = q_pc_q[head_q];
  assign bus.instr_valid = (count_q != '0);
  assign bus.fill_count  = count_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle table, hand-written corner sequences and a random
// run scored against an expected instruction stream derived from the program image.
module tb_instr_fetch_unit;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int FD = 4;
  localparam int CW = $clog2(FD + 1);

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [DW-1:0]    mem_m [2**AW];
  logic [DW+AW-1:0] exp_q [$];

  instr_fetch_unit_if #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD)) bus ();

  instr_fetch_unit #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD), .RESET_PC('0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          ready;
    logic          br;
    logic [AW-1:0] target;
    logic          exp_valid;
    logic [AW-1:0] exp_pc;
    logic [CW-1:0] exp_fill;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_head(input string name, input logic [AW-1:0] pc);
    check({name, "_valid"}, 32'(bus.instr_valid), 32'd1);
    check({name, "_pc"}, 32'(bus.instr_pc), 32'(pc));
    check({name, "_data"}, 32'(bus.instr), 32'(mem_m[pc]));
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.instr_ready = 1'b0;
    bus.branch_en   = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic prog_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.prog_we    = 1'b1;
    bus.prog_addr  = addr;
    bus.prog_wdata = data;
    step();
    bus.prog_we = 1'b0;
    mem_m[addr] = data;
  endtask

  // Redirect in the current cycle B; expects empty B+1, B+2 and target, target+1.. from B+3.
  task automatic branch_and_check(input string name, input logic [AW-1:0] target, input int n);
    bus.instr_ready   = 1'b1;
    bus.branch_en     = 1'b1;
    bus.branch_target = target;
    step();
    bus.branch_en = 1'b0;
    check({name, "_b1_valid"}, 32'(bus.instr_valid), 32'd0);
    check({name, "_b1_fill"}, 32'(bus.fill_count), 32'd0);
    step();
    check({name, "_b2_valid"}, 32'(bus.instr_valid), 32'd0);
    step();
    for (int k = 0; k < n; k++) begin
      check_head($sformatf("%s_seq%0d", name, k), target + AW'(k));
      step();
    end
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [AW-1:0] next_pc;
    logic [DW+AW-1:0] e;
    int bp_fill [9];
    int streak;
    int handshakes;
    logic r, b, rs;
    logic [AW-1:0] t;

    checks            = 0;
    failures          = 0;
    reset             = 1'b1;
    bus.instr_ready   = 1'b0;
    bus.branch_en     = 1'b0;
    bus.branch_target = '0;
    bus.prog_we       = 1'b0;
    bus.prog_addr     = '0;
    bus.prog_wdata    = '0;
    @(negedge clk);

    // Program image: i+100 at the bottom, a marked block at 0x200, random elsewhere.
    for (int a = 0; a < 2**AW; a++) begin
      if (a < 16)                       w = DW'(a + 100);
      else if (a >= 'h200 && a < 'h210) w = DW'('hA000 + a);
      else                              w = DW'($urandom);
      prog_write(AW'(a), w);
    end

    // ready held high from cycle 0, then a redirect to 0x200 in cycle 7
    vecs[0]  = '{1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 3'd0};
    vecs[1]  = '{1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 3'd0};
    vecs[2]  = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h000, 3'd1};
    vecs[3]  = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h001, 3'd1};
    vecs[4]  = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h002, 3'd1};
    vecs[5]  = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h003, 3'd1};
    vecs[6]  = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h004, 3'd1};
    vecs[7]  = '{1'b1, 1'b1, 10'h200, 1'b1, 10'h005, 3'd1};
    vecs[8]  = '{1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 3'd0};
    vecs[9]  = '{1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 3'd0};
    vecs[10] = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h200, 3'd1};
    vecs[11] = '{1'b1, 1'b0, 10'h000, 1'b1, 10'h201, 3'd1};

    do_reset();
    check("reset_valid", 32'(bus.instr_valid), 32'd0);
    check("reset_fill", 32'(bus.fill_count), 32'd0);
    for (int i = 0; i < 12; i++) begin
      bus.instr_ready   = vecs[i].ready;
      bus.branch_en     = vecs[i].br;
      bus.branch_target = vecs[i].target;
      check($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_fill", i), 32'(bus.fill_count), 32'(vecs[i].exp_fill));
      if (vecs[i].exp_valid) check_head($sformatf("vec%0d", i), vecs[i].exp_pc);
      step();
    end
    bus.branch_en = 1'b0;

    branch_and_check("wrap", 10'h3FE, 4);

    // Backpressure: fill to exactly FD, hold, then drain with no gap or duplicate.
    bp_fill = '{0, 0, 1, 2, 3, 4, 4, 4, 4};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      check($sformatf("bp_fill%0d", i), 32'(bus.fill_count), 32'(bp_fill[i]));
      step();
    end
    check_head("bp_hold", 10'h000);
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check_head($sformatf("bp_drain%0d", k), AW'(k));
      step();
    end

    // Redirect while three entries are queued and decode is ready.
    do_reset();
    for (int i = 0; i < 4; i++) step();
    check("flush_pre_fill", 32'(bus.fill_count), 32'd3);
    branch_and_check("flush", 10'h200, 2);

    // Write to address 5 in the cycle it is fetched: old value delivered, new after redirect.
    do_reset();
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    prog_write(10'h005, 16'hBEEF);
    check("selfmod_pc4", 32'(bus.instr_pc), 32'h004);
    step();
    check("selfmod_old_pc", 32'(bus.instr_pc), 32'h005);
    check("selfmod_old_data", 32'(bus.instr), 32'd105);
    branch_and_check("selfmod_new", 10'h005, 2);
    check("selfmod_literal", 32'(mem_m[5]), 32'hBEEF);
    prog_write(10'h005, 16'd105);

    // One-cycle reset with a full queue.
    do_reset();
    for (int i = 0; i < 7; i++) step();
    check("rst_full_fill", 32'(bus.fill_count), 32'd4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_mid_fill", 32'(bus.fill_count), 32'd0);
    bus.instr_ready = 1'b1;
    step();
    step();
    check_head("rst_restart", 10'h000);

    // Random run: delivered stream must be consecutive addresses from the last reset/redirect.
    do_reset();
    exp_q.delete();
    next_pc    = '0;
    streak     = 0;
    handshakes = 0;
    for (int c = 0; c < 3000; c++) begin
      while (exp_q.size() < 8) begin
        exp_q.push_back({mem_m[next_pc], next_pc});
        next_pc = next_pc + AW'(1);
      end
      r  = ($urandom_range(0, 3) != 0);
      b  = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 299) == 0);
      t  = AW'($urandom_range(0, 2**AW - 1));
      reset             = rs;
      bus.instr_ready   = r;
      bus.branch_en     = b;
      bus.branch_target = t;

      if (!bus.instr_valid) streak++;
      else                  streak = 0;
      check("rand_stall", 32'(streak <= 2), 32'd1);
      check("rand_valid_vs_fill", 32'(bus.instr_valid), 32'(bus.fill_count != '0));
      check("rand_fill_max", 32'(bus.fill_count <= CW'(FD)), 32'd1);

      if (rs) begin
        exp_q.delete();
        next_pc = '0;
        streak  = 0;
      end else if (b) begin
        exp_q.delete();
        next_pc = t;
        streak  = 0;
      end else if (bus.instr_valid && r) begin
        e = exp_q.pop_front();
        check("rand_instr", 32'({bus.instr, bus.instr_pc}), 32'(e));
        handshakes++;
      end
      step();
    end
    reset         = 1'b0;
    bus.branch_en = 1'b0;
    check("rand_progress", 32'(handshakes >= 1000), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
